program_sequencer: RTL and testbench

Controller that owns program load and execution handshake for the mini processor. A host fills an 8-entry instruction buffer, then pulses start. The block streams instructions into the processor's load port one per cycle, releases it to run with the correct PC range and output register, and waits for completion under a timeout. It replaces bench-driven instruction sequencing with a synthesizable sequencer between host and processor.

---
 rtl/program_sequencer_pkg.sv | 17 +
 rtl/program_sequencer_if.sv | 26 ++
 rtl/program_sequencer_seq_instr_buf.sv | 24 ++
 rtl/program_sequencer.sv | 132 +++++++++++++
 tb/tb_program_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared processor-wide types and widths for the program sequencer and its
// processor-facing interface.
package program_sequencer_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 3;
  localparam int REG_W   = 5;
  localparam int DEPTH   = 2 ** PC_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Load/run handshake between the sequencer (master) and the mini processor
// (slave).
interface program_sequencer_if import program_sequencer_pkg::*; ();

  logic [INSTR_W-1:0] proc_instr;
  logic               proc_instr_valid;
  logic [PC_W-1:0]    proc_load_pc;
  logic               proc_run;
  logic [PC_W-1:0]    proc_max_pc;
  logic [REG_W-1:0]   proc_out_reg;
  logic               proc_done;
  logic [PC_W-1:0]    proc_pc_final;

  modport master (
    output proc_instr, proc_instr_valid, proc_load_pc, proc_run,
           proc_max_pc, proc_out_reg,
    input  proc_done, proc_pc_final
  );

  modport slave (
    input  proc_instr, proc_instr_valid, proc_load_pc, proc_run,
           proc_max_pc, proc_out_reg,
    output proc_done, proc_pc_final
  );

endinterface

// File: rtl/program_sequencer_seq_instr_buf.sv
// Instruction buffer: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a program survives rst.
module seq_instr_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Sequencer between host and mini processor: buffers a program, streams it
// into the processor's load port, then supervises the run under a timeout.
module program_sequencer import program_sequencer_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [PC_W-1:0]     prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  input  logic                start,
  input  logic [PC_W:0]       num_instr,
  input  logic [REG_W-1:0]    out_reg,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic                len_err,
  output logic [PC_W-1:0]     final_pc,
  output logic [7:0]          run_cycles,
  program_sequencer_if.master proc
);

  localparam logic [PC_W:0] DEPTH_N  = (PC_W + 1)'(DEPTH);
  localparam logic [7:0]    TIMEOUT8 = 8'(TIMEOUT_CYCLES);

  seq_state_t         state, state_next;
  logic [PC_W-1:0]    idx;
  logic [PC_W-1:0]    max_pc_q;
  logic [REG_W-1:0]   out_reg_q;
  logic [INSTR_W-1:0] rd_data;
  logic [7:0]         run_inc;
  logic               n_legal;
  logic               accept;
  logic               len_bad;
  logic               finish_ok;
  logic               expire;
  logic               buf_we;

  // Buffer writes only land while idle, so a running program cannot be altered.
  assign buf_we  = (state == IDLE) && prog_we;
  assign n_legal = (num_instr != '0) && (num_instr <= DEPTH_N);
  assign run_inc = (run_cycles == 8'hFF) ? 8'hFF : run_cycles + 8'd1;

  seq_instr_buf #(
    .DEPTH (DEPTH),
    .AW    (PC_W),
    .W     (INSTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    len_bad    = 1'b0;
    finish_ok  = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (n_legal) begin
            accept     = 1'b1;
            state_next = LOAD;
          end else begin
            len_bad = 1'b1;
          end
        end
      end
      LOAD: begin
        if (idx == max_pc_q) state_next = RUN;
      end
      // Completion is checked before expiry so a late proc_done still wins.
      RUN: begin
        if (proc.proc_done) begin
          finish_ok  = 1'b1;
          state_next = DONE;
        end else if (run_inc >= TIMEOUT8) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      max_pc_q    <= '0;
      out_reg_q   <= '0;
      run_cycles  <= '0;
      final_pc    <= '0;
      timeout_err <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      len_err <= len_bad;
      if (accept) begin
        idx         <= '0;
        max_pc_q    <= num_instr[PC_W-1:0] - PC_W'(1);
        out_reg_q   <= out_reg;
        run_cycles  <= '0;
        final_pc    <= '0;
        timeout_err <= 1'b0;
      end
      if (state == LOAD) idx <= idx + PC_W'(1);
      if (state == RUN) run_cycles <= run_inc;
      if (finish_ok) final_pc <= proc.proc_pc_final;
      if (expire) timeout_err <= 1'b1;
    end
  end

  assign busy                  = (state != IDLE);
  assign done                  = (state == DONE);
  assign proc.proc_instr_valid = (state == LOAD);
  assign proc.proc_instr       = (state == LOAD) ? rd_data : '0;
  assign proc.proc_load_pc     = (state == LOAD) ? idx : '0;
  assign proc.proc_run         = (state == RUN);
  assign proc.proc_max_pc      = max_pc_q;
  assign proc.proc_out_reg     = out_reg_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a vector table of programs plus
// hand sequences, with a scoreboard for the streamed instructions.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  n;
    logic [4:0]  oreg;
    int          done_at;
    logic [2:0]  pc;
    logic        poke;
    logic        exp_len;
    logic        exp_done;
    logic        exp_to;
    int          exp_rc;
    logic [2:0]  exp_final;
  } vec_t;

  typedef struct {
    logic [2:0]  pc;
    logic [31:0] instr;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [31:0] prog_data;
  logic        start;
  logic [3:0]  num_instr;
  logic [4:0]  out_reg;
  logic        busy, done, timeout_err, len_err;
  logic [2:0]  final_pc;
  logic [7:0]  run_cycles;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] model_mem [8];
  sb_t         sb [$];
  vec_t        vecs [8];

  program_sequencer_if pif ();

  program_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .num_instr   (num_instr),
    .out_reg     (out_reg),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .len_err     (len_err),
    .final_pc    (final_pc),
    .run_cycles  (run_cycles),
    .proc        (pif)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of host inputs; the model and scoreboard follow what the DUT should accept.
  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] data,
                               input logic st, input logic [3:0] n, input logic [4:0] oreg);
    @(posedge clk); #1;
    prog_we = we; prog_addr = addr; prog_data = data;
    start = st; num_instr = n; out_reg = oreg;
    if (we) model_mem[addr] = data;
    if (st && n >= 4'd1 && n <= 4'd8)
      for (int i = 0; i < int'(n); i++) sb.push_back('{pc: 3'(i), instr: model_mem[i]});
    @(posedge clk); #1;
    prog_we = 1'b0;
    start   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pif.proc_instr_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 32'(pif.proc_instr_valid), 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          checkOutput("load_pc", 32'(pif.proc_load_pc), 32'(e.pc));
          checkOutput("load_instr", pif.proc_instr, e.instr);
        end
      end else begin
        checkOutput("instr_zero_when_invalid", pif.proc_instr, 32'd0);
      end
    end
  end

  task automatic runVector(input vec_t v);
    int  vcnt;
    int  c;
    bit  got_run;
    applyStimulus(v.we, v.waddr, v.wdata, 1'b1, v.n, v.oreg);
    checkOutput("len_err", 32'(len_err), 32'(v.exp_len));
    checkOutput("busy_after_start", 32'(busy), 32'(!v.exp_len));
    if (v.exp_len) begin
      @(posedge clk); #1;
      checkOutput("len_err_pulse_end", 32'(len_err), 32'd0);
      checkOutput("busy_after_len_err", 32'(busy), 32'd0);
      return;
    end
    checkOutput("timeout_cleared", 32'(timeout_err), 32'd0);
    checkOutput("proc_max_pc", 32'(pif.proc_max_pc), 32'(v.n) - 32'd1);
    checkOutput("proc_out_reg", 32'(pif.proc_out_reg), 32'(v.oreg));
    vcnt = 0;
    got_run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pif.proc_run) begin
        got_run = 1'b1;
        break;
      end
      if (pif.proc_instr_valid) vcnt++;
    end
    checkOutput("load_cycles", 32'(vcnt), 32'(v.n));
    checkOutput("run_reached", 32'(got_run), 32'd1);
    if (!got_run) return;
    c = 1;
    while (c <= 300) begin
      if (c == v.done_at) begin
        pif.proc_done = 1'b1;
        pif.proc_pc_final = v.pc;
      end
      if (v.poke && c == 2) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 3'd0;
        prog_data = 32'h12345678; num_instr = 4'd3;
      end
      @(posedge clk); #1;
      pif.proc_done = 1'b0;
      pif.proc_pc_final = 3'd0;
      start = 1'b0;
      prog_we = 1'b0;
      if (!pif.proc_run) break;
      c++;
      @(negedge clk);
    end
    checkOutput("run_bounded", 32'(c <= 300), 32'd1);
    checkOutput("done", 32'(done), 32'(v.exp_done));
    checkOutput("timeout_err", 32'(timeout_err), 32'(v.exp_to));
    checkOutput("run_cycles", 32'(run_cycles), 32'(v.exp_rc));
    checkOutput("max_pc_held", 32'(pif.proc_max_pc), 32'(v.n) - 32'd1);
    if (v.exp_done) checkOutput("final_pc", 32'(final_pc), 32'(v.exp_final));
    @(posedge clk); #1;
    checkOutput("done_pulse_end", 32'(done), 32'd0);
    checkOutput("idle_after_run", 32'(busy), 32'd0);
    checkOutput("run_cycles_hold", 32'(run_cycles), 32'(v.exp_rc));
  endtask

  initial begin
    rst = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; num_instr = '0; out_reg = '0;
    pif.proc_done = 1'b0; pif.proc_pc_final = '0;

    //            we  wa    wdata         n   oreg   dn  pc   pk  len dn  to  rc  fin
    vecs[0] = '{1'b0, 3'd0, 32'h0,        4'd6, 5'd6,  4, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0,  4, 3'd5};
    vecs[1] = '{1'b0, 3'd0, 32'h0,        4'd0, 5'd1,  0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0,  0, 3'd0};
    vecs[2] = '{1'b0, 3'd0, 32'h0,        4'd9, 5'd1,  0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0,  0, 3'd0};
    vecs[3] = '{1'b0, 3'd0, 32'h0,        4'd1, 5'd3,  0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64, 3'd0};
    vecs[4] = '{1'b0, 3'd0, 32'h0,        4'd2, 5'd7, 64, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 64, 3'd1};
    vecs[5] = '{1'b0, 3'd0, 32'h0,        4'd8, 5'd31, 1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0,  1, 3'd7};
    vecs[6] = '{1'b0, 3'd0, 32'h0,        4'd4, 5'd2,  6, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0,  6, 3'd3};
    vecs[7] = '{1'b1, 3'd0, 32'hDEADBEEF, 4'd1, 5'd0,  2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0,  2, 3'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_run_cycles", 32'(run_cycles), 32'd0);
    checkOutput("reset_final_pc", 32'(final_pc), 32'd0);
    checkOutput("reset_valid", 32'(pif.proc_instr_valid), 32'd0);
    checkOutput("reset_run", 32'(pif.proc_run), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] loading basic program");
    applyStimulus(1'b1, 3'd0, 32'h1401002D, 1'b0, 4'd0, 5'd0);
    applyStimulus(1'b1, 3'd1, 32'h1402FFEC, 1'b0, 4'd0, 5'd0);
    applyStimulus(1'b1, 3'd2, 32'h1403FFC4, 1'b0, 4'd0, 5'd0);
    applyStimulus(1'b1, 3'd3, 32'h00222821, 1'b0, 4'd0, 5'd0);
    applyStimulus(1'b1, 3'd4, 32'h00643021, 1'b0, 4'd0, 5'd0);
    applyStimulus(1'b1, 3'd5, 32'h00A62823, 1'b0, 4'd0, 5'd0);
    applyStimulus(1'b1, 3'd6, 32'hA5A50006, 1'b0, 4'd0, 5'd0);
    applyStimulus(1'b1, 3'd7, 32'hA5A50007, 1'b0, 4'd0, 5'd0);

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d", i);
      runVector(vecs[i]);
    end

    $display("[TB] reset during load");
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 4'd6, 5'd6);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pif.proc_instr_valid && pif.proc_load_pc == 3'd3) break;
    end
    checkOutput("reached_slot3", 32'(pif.proc_load_pc), 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(pif.proc_instr_valid), 32'd0);
    checkOutput("rst_instr", pif.proc_instr, 32'd0);
    checkOutput("rst_load_pc", 32'(pif.proc_load_pc), 32'd0);
    checkOutput("rst_max_pc", 32'(pif.proc_max_pc), 32'd0);
    checkOutput("rst_out_reg", 32'(pif.proc_out_reg), 32'd0);
    checkOutput("rst_run_cycles", 32'(run_cycles), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    runVector(vecs[0]);

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
